// File: rtl/benes_cfg_sched_pkg.sv
`default_nettype none
// =============================================================================
// Module   : benes_cfg_sched_pkg
// Desc     : Shared constants and types for the Benes configuration scheduler.
// Revision : 1.0
// =============================================================================
package benes_cfg_sched_pkg;

  localparam int BENES_N            = 32;
  localparam int BENES_STAGES       = 2*$clog2(BENES_N)-1;
  localparam int BENES_SW_PER_STAGE = BENES_N/2;

  typedef logic [BENES_SW_PER_STAGE-1:0] stage_cfg_t;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_RUN   = 1'b1
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/benes_cfg_loader.sv
`default_nettype none
// =============================================================================
// Module   : benes_cfg_loader
// Desc     : Shadow bank loader: one stage per beat, framing (and optional
//            parity, macro BENES_CFG_PARITY_EN) checks, shadow_full flag.
// Revision : 1.0
// =============================================================================
module benes_cfg_loader
  import benes_cfg_sched_pkg::*;
#(
  parameter int STAGES       = BENES_STAGES,
  parameter int SW_PER_STAGE = BENES_SW_PER_STAGE
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [SW_PER_STAGE-1:0]        cfg_bits,
  input  logic                           cfg_last,
`ifdef BENES_CFG_PARITY_EN
  input  logic                           cfg_par,
`endif
  input  logic                           shadow_take,
  output logic                           shadow_full,
  output logic [STAGES*SW_PER_STAGE-1:0] shadow_bank,
  output logic                           cfg_err
);

  localparam int LW = $clog2(STAGES);
  localparam logic [LW-1:0] C_LAST_IDX = LW'(STAGES-1);

  logic [LW-1:0]                  r_ld_cnt;
  logic                           r_full;
  logic                           r_err;
  logic [STAGES*SW_PER_STAGE-1:0] r_shadow;

  logic w_accept;
  logic w_at_last;
  logic w_bad_par;
  logic w_bad_beat;

  assign w_accept  = cfg_valid & ~r_full;
  assign w_at_last = (r_ld_cnt == C_LAST_IDX);

`ifdef BENES_CFG_PARITY_EN
  // Even parity: cfg_par plus {cfg_last, cfg_bits} must XOR to zero.
  assign w_bad_par = cfg_par ^ (^{cfg_last, cfg_bits});
`else
  assign w_bad_par = 1'b0;
`endif

  assign w_bad_beat = w_bad_par | (cfg_last != w_at_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_cnt <= '0;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
      r_shadow <= '0;
    end else begin
      r_err <= 1'b0;
      if (shadow_take) begin
        r_full <= 1'b0;
      end
      if (w_accept) begin
        r_shadow[r_ld_cnt*SW_PER_STAGE +: SW_PER_STAGE] <= cfg_bits;
        if (w_bad_beat) begin
          // Whatever is already in the shadow is abandoned; next beat is stage 0.
          r_err    <= 1'b1;
          r_ld_cnt <= '0;
        end else if (w_at_last) begin
          r_full   <= 1'b1;
          r_ld_cnt <= '0;
        end else begin
          r_ld_cnt <= r_ld_cnt + 1'b1;
        end
      end
    end
  end

  assign cfg_ready   = ~r_full;
  assign shadow_full = r_full;
  assign shadow_bank = r_shadow;
  assign cfg_err     = r_err;

endmodule
`default_nettype wire

// File: rtl/benes_cfg_sched.sv
`default_nettype none
// =============================================================================
// Module   : benes_cfg_sched
// Desc     : Benes network configuration scheduler; promotes the shadow bank to
//            the active bank only on frame boundaries. Optional macro:
//            BENES_CFG_PARITY_EN (adds cfg_par input).
// Revision : 1.0
// =============================================================================
module benes_cfg_sched
  import benes_cfg_sched_pkg::*;
#(
  parameter int N            = BENES_N,
  parameter int STAGES       = 2*$clog2(N)-1,
  parameter int SW_PER_STAGE = N/2,
  parameter int FRAME_LEN    = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [SW_PER_STAGE-1:0]        cfg_bits,
  input  logic                           cfg_last,
`ifdef BENES_CFG_PARITY_EN
  input  logic                           cfg_par,
`endif
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [STAGES*SW_PER_STAGE-1:0] switch_set,
  output logic                           cfg_active,
  output logic                           cfg_swap,
  output logic                           cfg_err
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] C_FR_LAST = FW'(FRAME_LEN-1);

  sched_state_e                   r_state;
  logic [FW-1:0]                  r_fr_cnt;
  logic [STAGES*SW_PER_STAGE-1:0] r_active;

  logic                           w_shadow_full;
  logic [STAGES*SW_PER_STAGE-1:0] w_shadow;
  logic                           w_swap;
  logic                           w_beat;

  benes_cfg_loader #(
    .STAGES       (STAGES),
    .SW_PER_STAGE (SW_PER_STAGE)
  ) u_loader (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_bits    (cfg_bits),
    .cfg_last    (cfg_last),
`ifdef BENES_CFG_PARITY_EN
    .cfg_par     (cfg_par),
`endif
    .shadow_take (w_swap),
    .shadow_full (w_shadow_full),
    .shadow_bank (w_shadow),
    .cfg_err     (cfg_err)
  );

  // A swap at fr_cnt==0 wins over data: in_ready drops so no beat can slip
  // through while the bank is being replaced.
  assign w_swap   = w_shadow_full & ((r_state == S_EMPTY) | (r_fr_cnt == '0));
  assign in_ready = (r_state == S_RUN) & ~w_swap;
  assign w_beat   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_EMPTY;
      r_fr_cnt <= '0;
      r_active <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_swap) begin
            r_active <= w_shadow;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_swap) begin
            r_active <= w_shadow;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
      if (w_beat) begin
        r_fr_cnt <= (r_fr_cnt == C_FR_LAST) ? '0 : r_fr_cnt + 1'b1;
      end
    end
  end

  assign switch_set = r_active;
  assign cfg_active = (r_state == S_RUN);
  assign cfg_swap   = w_swap;

endmodule
`default_nettype wire
